// File: rtl/rgb_pwm_sequencer.sv
// RGB LED driver sequencer: power-up/down around a settle interval, 3-ch PWM.
// Optional breathing brightness ramp enabled by defining RGB_BREATHE_EN.
module rgb_pwm_sequencer #(
  parameter int PRESCALE_W = 8,
  parameter int SETTLE_CYC = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [2:0] rgb_pwm,
  output logic       rgbled_en,
  output logic       cbit_rgb_en,
  output logic       cbit_rgb_half_cur,
  output logic [1:0] seq_state
);

  localparam int SW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t state;

  logic [2:0]            ctrl;
  logic [PRESCALE_W-1:0] presc;
  logic [2:0][7:0]       duty;
  logic [2:0][7:0]       duty_nx;
  logic [2:0][7:0]       duty_sh;
  logic [2:0][7:0]       eff;
  logic [7:0]            bstep;

  logic [SW-1:0]         scnt;
  logic [PRESCALE_W-1:0] pcnt;
  logic [7:0]            fcnt;
  logic                  tick;
  logic                  run_go;
  logic                  frame;

  assign seq_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl  <= '0;
      presc <= '0;
      duty  <= '0;
      bstep <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    ctrl    <= cfg_wdata[2:0];
        3'd1:    presc   <= PRESCALE_W'(cfg_wdata);
        3'd2:    duty[0] <= cfg_wdata;
        3'd3:    duty[1] <= cfg_wdata;
        3'd4:    duty[2] <= cfg_wdata;
        3'd5:    bstep   <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // A write coinciding with a shadow load must win, so bypass the register.
  always_comb begin
    duty_nx = duty;
    if (cfg_we) begin
      for (int n = 0; n < 3; n++) begin
        if (cfg_addr == 3'(n + 2)) duty_nx[n] = cfg_wdata;
      end
    end
  end

  assign tick   = (pcnt == presc);
  assign run_go = (state == S_SETTLE) && ctrl[0] && (scnt == LAST);
  assign frame  = (state == S_RUN) && ctrl[0] && tick && (fcnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh <= '0;
    end else if (run_go || frame) begin
      duty_sh <= duty_nx;
    end
  end

`ifdef RGB_BREATHE_EN
  logic [7:0]       bstep_nx;
  logic [7:0]       bstep_sh;
  logic [7:0]       bright;
  logic [7:0]       bcnt;
  logic             up;
  logic [7:0]       blev;
  logic [15:0]      scale;
  logic [2:0][15:0] prod;

  assign bstep_nx = (cfg_we && cfg_addr == 3'd5) ? cfg_wdata : bstep;
  assign blev     = ctrl[1] ? bright : 8'hFF;
  assign scale    = {8'd0, blev} + 16'd1;

  always_comb begin
    prod = '0;
    eff  = '0;
    for (int n = 0; n < 3; n++) begin
      prod[n] = {8'd0, duty_sh[n]} * scale;
      eff[n]  = prod[n][15:8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bstep_sh <= '0;
      bright   <= '0;
      bcnt     <= '0;
      up       <= 1'b1;
    end else if (run_go) begin
      bstep_sh <= bstep_nx;
      bright   <= '0;
      bcnt     <= '0;
      up       <= 1'b1;
    end else if (frame) begin
      bstep_sh <= bstep_nx;
      if (ctrl[1]) begin
        if (bcnt >= bstep_sh) begin
          bcnt <= '0;
          // Turn around one step early so the ramp touches 255 and 0 once.
          if (up) begin
            bright <= bright + 8'd1;
            if (bright == 8'hFE) up <= 1'b0;
          end else begin
            bright <= bright - 8'd1;
            if (bright == 8'h01) up <= 1'b1;
          end
        end else begin
          bcnt <= bcnt + 8'd1;
        end
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{bstep, ctrl[1]};
  assign eff        = duty_sh;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_OFF;
      scnt              <= '0;
      pcnt              <= '0;
      fcnt              <= '0;
      rgb_pwm           <= '0;
      rgbled_en         <= 1'b0;
      cbit_rgb_en       <= 1'b0;
      cbit_rgb_half_cur <= 1'b0;
    end else begin
      unique case (state)
        S_OFF: begin
          cbit_rgb_half_cur <= ctrl[2];
          if (ctrl[0]) begin
            state       <= S_SETTLE;
            scnt        <= '0;
            rgbled_en   <= 1'b1;
            cbit_rgb_en <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (!ctrl[0]) begin
            state <= S_STOP;
            scnt  <= '0;
          end else if (scnt == LAST) begin
            state <= S_RUN;
            pcnt  <= '0;
            fcnt  <= '0;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!ctrl[0]) begin
            state   <= S_STOP;
            scnt    <= '0;
            rgb_pwm <= '0;
          end else begin
            for (int n = 0; n < 3; n++) begin
              rgb_pwm[n] <= (fcnt < eff[n]);
            end
            if (tick) begin
              pcnt <= '0;
              fcnt <= fcnt + 8'd1;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (scnt == LAST) begin
            state             <= S_OFF;
            rgbled_en         <= 1'b0;
            cbit_rgb_en       <= 1'b0;
            cbit_rgb_half_cur <= ctrl[2];
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Scoreboard bench for rgb_pwm_sequencer: per-cycle expected output words.
// Breathe ramp checks are compiled only when RGB_BREATHE_EN is defined.
module tb_rgb_pwm_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [2:0] rgb_pwm;
  logic       rgbled_en;
  logic       cbit_rgb_en;
  logic       cbit_rgb_half_cur;
  logic [1:0] seq_state;

  rgb_pwm_sequencer #(
    .PRESCALE_W(8),
    .SETTLE_CYC(64)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_we           (cfg_we),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .rgb_pwm          (rgb_pwm),
    .rgbled_en        (rgbled_en),
    .cbit_rgb_en      (cbit_rgb_en),
    .cbit_rgb_half_cur(cbit_rgb_half_cur),
    .seq_state        (seq_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] e;
    int         tag;
  } exp_t;

  exp_t sb[$];
  exp_t it;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  wire [7:0] obs = {seq_state, rgbled_en, cbit_rgb_en,
                    cbit_rgb_half_cur, rgb_pwm};

  function automatic string tname(int t);
    case (t)
      0:       return "reset";
      1:       return "idle";
      2:       return "settle";
      3:       return "run_entry";
      4:       return "stop";
      5:       return "off_half";
      6:       return "resettle";
      7:       return "rerun";
      8:       return "async_rst";
      9:       return "post_rst";
      10:      return "breathe";
      default: return $sformatf("pwm_frame%0d", t - 20);
    endcase
  endfunction

  function automatic logic [7:0] ob(logic [1:0] s, logic en,
                                    logic h, logic [2:0] p);
    return {s, en, en, h, p};
  endfunction

  function automatic void expect_at(int c, logic [7:0] e, int t);
    exp_t x;
    x.c = c;
    x.e = e;
    x.tag = t;
    sb.push_back(x);
  endfunction

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares every expectation due at this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].c <= cyc) begin
        it = sb.pop_front();
        checks++;
        if (it.c != cyc) begin
          errors++;
          $display("FAIL %s: cycle %0d not sampled, now %0d",
                   tname(it.tag), it.c, cyc);
        end else if (obs !== it.e) begin
          errors++;
          $display("FAIL %s cyc %0d: got %b want %b",
                   tname(it.tag), cyc, obs, it.e);
        end
      end
      if (done) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL leftover: %0d unchecked, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, r, m, r2, k, f, d0, d1;
    logic [2:0] p;

    @(posedge clk);
    #1;
    expect_at(1, 8'h00, 0);
    #2 rst_n = 1'b1;
    for (int c = 2; c <= 4; c++) expect_at(c, 8'h00, 1);

    wr(3'd1, 8'd3);
    wr(3'd2, 8'd64);
    wr(3'd3, 8'd0);
    wr(3'd4, 8'd255);
    wr(3'd0, 8'd1);
    e = cyc;

    for (int c = e + 1; c <= e + 64; c++)
      expect_at(c, ob(2'd1, 1'b1, 1'b0, 3'b000), 2);
    r = e + 65;
    expect_at(r, ob(2'd2, 1'b1, 1'b0, 3'b000), 3);
    m = r + 4200;
    for (int j = 0; j <= m - r - 1; j++) begin
      k = j / 1024;
      f = (j / 4) % 256;
      d0 = (k >= 2) ? 128 : 64;
      d1 = (k >= 3) ? 32 : 0;
      p = {f < 255, f < d1, f < d0};
      expect_at(r + 1 + j, ob(2'd2, 1'b1, 1'b0, p), 20 + k);
    end

    goto(r + 1499);
    wr(3'd2, 8'd128);
    goto(r + 3071);
    wr(3'd3, 8'd32);
    goto(m - 1);
    wr(3'd0, 8'd0);

    for (int c = m + 1; c <= m + 64; c++)
      expect_at(c, ob(2'd3, 1'b1, 1'b0, 3'b000), 4);
    expect_at(m + 65, ob(2'd0, 1'b0, 1'b1, 3'b000), 5);
    for (int c = m + 66; c <= m + 129; c++)
      expect_at(c, ob(2'd1, 1'b1, 1'b1, 3'b000), 6);
    r2 = m + 130;
    expect_at(r2, ob(2'd2, 1'b1, 1'b1, 3'b000), 7);
    for (int j = 0; j <= 48; j++)
      expect_at(r2 + 1 + j, ob(2'd2, 1'b1, 1'b1, 3'b111), 7);

    goto(m + 19);
    wr(3'd0, 8'd5);

    goto(r2 + 49);
    expect_at(r2 + 50, 8'h00, 8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = r2 + 51; c <= r2 + 60; c++) expect_at(c, 8'h00, 9);
    goto(r2 + 60);

`ifdef RGB_BREATHE_EN
    wr(3'd1, 8'd0);
    wr(3'd2, 8'd255);
    wr(3'd5, 8'd0);
    wr(3'd0, 8'd3);
    e = cyc;
    for (int c = e + 1; c <= e + 64; c++)
      expect_at(c, ob(2'd1, 1'b1, 1'b0, 3'b000), 2);
    r = e + 65;
    expect_at(r, ob(2'd2, 1'b1, 1'b0, 3'b000), 3);
    for (int j = 0; j < 260 * 256; j++) begin
      k = j / 256;
      f = j % 256;
      d0 = (k <= 255) ? k : 510 - k;
      p = {2'b00, f < d0};
      expect_at(r + 1 + j, ob(2'd2, 1'b1, 1'b0, p), 10);
    end
    goto(r + 260 * 256 + 2);
`else
    goto(r2 + 62);
`endif

    done = 1'b1;
  end

endmodule

// File: doc/rgb_pwm_sequencer.md
# rgb_pwm_sequencer

Clocked controller for the three-channel 24 mA RGB LED driver block. It sequences driver power-up and power-down (rgbled_en, cbit_rgb_en) around a reference settle interval. It generates the three rgb_pwm bits from per-channel 8-bit duty registers on a prescaled PWM frame. An optional breathing engine scales all duties by a triangular brightness ramp. It sits between the SoC register bus and the driver pad macro.

## Interface
- PRESCALE_W, 8, width of prescaler register and counter
- SETTLE_CYC, 64, clk cycles that rgbled_en must be high before the first PWM high, and that it is held after the last one (≥2)
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- cfg_we  input  1  register write strobe, one cycle per write
- cfg_addr  input  3  register address
- cfg_wdata  input  8  write data (PRESC uses the low PRESCALE_W bits, zero-extended/truncated)
- rgb_pwm  output  3  PWM to driver, bit n = channel n
- rgbled_en  output  1  driver analog enable
- cbit_rgb_en  output  1  driver current-source enable
- cbit_rgb_half_cur  output  1  driver half-current select
- seq_state  output  2  0 OFF, 1 SETTLE, 2 RUN, 3 STOP

Register map:
- 0 CTRL: bit0 EN, bit1 BREATHE, bit2 HALF
- 1 PRESC
- 2/3/4 DUTY0/1/2
- 5 BSTEP

All registers reset to 0. Unmapped addresses are ignored.

## Operation
- Register writes land on the cfg_we edge and are visible the next cycle.
- DUTYn and BSTEP are shadowed. Shadows load only at a frame boundary (frame counter wrapping 255→0), and on entry to RUN.
- Prescaler: counts 0..PRESC. A tick is issued on the cycle it equals PRESC, then it wraps to 0. PRESC=0 gives a tick every cycle.
- Frame counter: 8 bits, advances on each tick, wraps 255→0. It is a frame boundary each time it wraps.
- Channel output: rgb_pwm[n] = RUN && (fcnt < duty_eff[n]), registered.
  - duty 0 → constant low.
  - duty 255 → high 255 of 256 ticks.
- FSM:
  - OFF: all outputs 0. EN=1 → SETTLE.
  - SETTLE: rgbled_en=1, cbit_rgb_en=1, pwm=0. Settle counter counts SETTLE_CYC cycles, then → RUN. EN=0 → STOP.
  - RUN: prescaler and frame counter start from 0 on entry; pwm active. EN=0 → STOP.
  - STOP: pwm forced 0 on entry cycle; rgbled_en and cbit_rgb_en held for SETTLE_CYC cycles, then → OFF. EN is ignored until OFF is reached.
- cbit_rgb_half_cur = CTRL.HALF, registered. It changes only while in OFF; writes in other states are applied on the next entry to OFF.
- Reset mid-operation: every output goes to 0 immediately (asynchronously), and the FSM returns to OFF.

## Timing
- EN write on edge N:
  - seq_state=SETTLE, rgbled_en=1 and cbit_rgb_en=1 from N+1.
  - seq_state=RUN at N+1+SETTLE_CYC.
  - First rgb_pwm high (for a nonzero duty) one cycle after RUN entry.
- EN cleared on edge M in RUN:
  - rgb_pwm=0 and seq_state=STOP from M+1.
  - rgbled_en=0 and seq_state=OFF at M+1+SETTLE_CYC.
- PWM period = 256·(PRESC+1) cycles.
- A DUTY write takes effect at the next frame boundary. The current frame is never truncated and never glitched.
- Simultaneous frame boundary and DUTY write on the same edge: the shadow takes the new value.

## Configuration
- RGB_BREATHE_EN defined:
  - 8-bit brightness ramp `bright`, reset 0, up-direction.
  - With CTRL.BREATHE=1 in RUN, bright steps ±1 every BSTEP+1 frame boundaries. Direction reverses on reaching 255 or 0, giving a triangle wave.
  - duty_eff = (duty·(bright+1))>>8 (16-bit product).
  - With BREATHE=0, bright holds at 255.
  - bright reloads 0/up on RUN entry.
- RGB_BREATHE_EN undefined:
  - duty_eff = duty.
  - CTRL.BREATHE and BSTEP are stored but have no effect.
  - No multiplier is synthesized.

## Test plan
- Reset, then write CTRL=1 with SETTLE_CYC=64 → rgbled_en rises 1 cycle after the write; seq_state=RUN exactly 64 cycles later; rgb_pwm stays 0 throughout SETTLE.
- PRESC=3, DUTY0=64, DUTY1=0, DUTY2=255 → per 1024-cycle frame:
  - ch0 high 256 cycles.
  - ch1 never high.
  - ch2 high 1020 cycles.
- Write DUTY0 128 mid-frame → current frame keeps 64, next frame shows 128, no extra edges.
- Clear EN in RUN → pwm 0 next cycle; rgbled_en falls after 64 cycles. Re-setting EN during STOP → only after OFF does SETTLE start.
- Assert rst_n low mid-RUN → all outputs 0 without waiting for a clock edge. After release, seq_state=OFF and CTRL=0.
- With RGB_BREATHE_EN, BREATHE=1, BSTEP=0, PRESC=0, DUTY0=255:
  - ch0 high time rises by 1 tick per frame.
  - Peaks at frame 255 (255 ticks).
  - Then falls; bright returns to 0 at frame 510.
